// File: rtl/multi_cycle_pkg.sv
// Purpose : shared state encodings, opcode constants and stack-op codes for
//           the multi-cycle controller.
// Latency : n/a (declarations only). Backpressure: n/a.
package multi_cycle_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_FAULT  = 3'd5
  } state_e;

  // Opcodes 0xxx are ALU operations, aluOp = ir_1[2:0].
  localparam logic [3:0] OP_LOAD   = 4'b1000;
  localparam logic [3:0] OP_STORE  = 4'b1001;
  localparam logic [3:0] OP_BRANCH = 4'b1010;
  localparam logic [3:0] OP_JUMP   = 4'b1011;
  localparam logic [3:0] OP_PUSH   = 4'b1100;
  localparam logic [3:0] OP_POP    = 4'b1101;
  localparam logic [3:0] OP_CALL   = 4'b1110;
  localparam logic [3:0] OP_RET    = 4'b1111;

  localparam logic [1:0] PP_NONE = 2'b00;
  localparam logic [1:0] PP_PUSH = 2'b01;
  localparam logic [1:0] PP_POP  = 2'b10;

endpackage

// File: rtl/stack_depth_guard.sv
// Purpose : tracks datapath stack occupancy (0..STACK_DEPTH) and flags an
//           overflowing push or underflowing pop in the same cycle.
// Latency : fault_o is combinational; depth updates on the next edge.
// Ports   : clk_i, reset_i (sync, active-high), push_i / pop_i (stack op in
//           EXEC this cycle), fault_o (this op would over/underflow).
module stack_depth_guard #(
  parameter int STACK_DEPTH = 8
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic push_i,
  input  logic pop_i,
  output logic fault_o
);

  localparam int DW = $clog2(STACK_DEPTH + 1);
  localparam logic [DW-1:0] DEPTH_MAX = DW'(STACK_DEPTH);

  logic [DW-1:0] depth_q, depth_d;

  always_comb begin
    depth_d = depth_q;
    fault_o = (push_i && (depth_q == DEPTH_MAX)) ||
              (pop_i  && (depth_q == '0));
    // A faulting op is not executed, so the count is left untouched.
    if (!fault_o) begin
      if (push_i) begin
        depth_d = depth_q + 1'b1;
      end else if (pop_i) begin
        depth_d = depth_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      depth_q <= '0;
    end else begin
      depth_q <= depth_d;
    end
  end

endmodule

// File: rtl/multi_cycle_controller.sv
// Purpose : FETCH/DECODE/EXEC/MEM/WB control FSM driving datapath strobes,
//           PC and IR load enables from the IR opcode fields.
// Latency : ALU/store/pop 4 cycles, load 5, branch/jump/push/call/return 3.
// Backpressure: mem_ready=0 holds FETCH or MEM with memReq held high.
// Ports   : clk, reset (sync, active-high); ir_1/ir_2/ir_3 IR fields, flags
//           {v,c,n,z}, mem_ready; datapath strobes out, state (debug), fault.
// Option  : define STACK_GUARD_EN to add stack depth checking and the sticky
//           FAULT state; otherwise fault is tied to 0.
module multi_cycle_controller
  import multi_cycle_pkg::*;
#(
  parameter int STACK_DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] ir_1,
  input  logic [1:0] ir_2,
  input  logic [1:0] ir_3,
  input  logic [3:0] flags,
  input  logic       mem_ready,
  output logic [2:0] aluOp,
  output logic       memReq,
  output logic       memReadWrite,
  output logic       irLoad,
  output logic       pcLoad,
  output logic       branch,
  output logic       regLoad,
  output logic [1:0] muxPP,
  output logic       muxpush,
  output logic       muxreturn,
  output logic       intisCond,
  output logic       intisLoad,
  output logic [2:0] state,
  output logic       fault
);

  state_e state_q, state_d;
  logic   guard_fault;

  // The register field goes straight to the datapath.
  logic [1:0] unused_ir_3;
  assign unused_ir_3 = ir_3;

`ifdef STACK_GUARD_EN
  logic push_exec, pop_exec;
  assign push_exec = (state_q == ST_EXEC) && ((ir_1 == OP_PUSH) || (ir_1 == OP_CALL));
  assign pop_exec  = (state_q == ST_EXEC) && ((ir_1 == OP_POP)  || (ir_1 == OP_RET));

  stack_depth_guard #(
    .STACK_DEPTH(STACK_DEPTH)
  ) u_stack_depth_guard (
    .clk_i  (clk),
    .reset_i(reset),
    .push_i (push_exec),
    .pop_i  (pop_exec),
    .fault_o(guard_fault)
  );
`else
  localparam int unused_stack_depth = STACK_DEPTH;
  assign guard_fault = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    aluOp        = 3'b000;
    memReq       = 1'b0;
    memReadWrite = 1'b0;
    irLoad       = 1'b0;
    pcLoad       = 1'b0;
    branch       = 1'b0;
    regLoad      = 1'b0;
    muxPP        = PP_NONE;
    muxpush      = 1'b0;
    muxreturn    = 1'b0;
    intisCond    = 1'b0;
    intisLoad    = 1'b0;
    fault        = 1'b0;
    state        = state_q;

    unique case (state_q)
      ST_FETCH: begin
        memReq = 1'b1;
        if (mem_ready) begin
          irLoad  = 1'b1;
          pcLoad  = 1'b1;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC: begin
        if (!ir_1[3]) begin
          aluOp   = ir_1[2:0];
          state_d = ST_WB;
        end else if (guard_fault) begin
          // Stack strobes are suppressed so the datapath is left intact.
          state_d = ST_FAULT;
        end else begin
          state_d = ST_FETCH;
          case (ir_1)
            OP_LOAD, OP_STORE: state_d = ST_MEM;  // aluOp 000 forms the address
            OP_BRANCH: begin
              branch = flags[ir_2];
              pcLoad = flags[ir_2];
            end
            OP_JUMP: begin
              branch = 1'b1;
              pcLoad = 1'b1;
            end
            OP_PUSH: muxPP = PP_PUSH;
            OP_POP: begin
              muxPP   = PP_POP;
              state_d = ST_WB;
            end
            OP_CALL: begin
              muxPP   = PP_PUSH;
              muxpush = 1'b1;
              branch  = 1'b1;
              pcLoad  = 1'b1;
            end
            OP_RET: begin
              muxPP     = PP_POP;
              muxreturn = 1'b1;
              pcLoad    = 1'b1;
            end
            default: state_d = ST_FETCH;
          endcase
        end
      end
      ST_MEM: begin
        memReq       = 1'b1;
        memReadWrite = (ir_1 == OP_STORE);
        if (mem_ready) begin
          state_d = (ir_1 == OP_STORE) ? ST_FETCH : ST_WB;
        end
      end
      ST_WB: begin
        regLoad = 1'b1;
        state_d = ST_FETCH;
      end
      ST_FAULT: begin
`ifdef STACK_GUARD_EN
        fault = 1'b1;
`endif
        state_d = ST_FAULT;
      end
      default: state_d = ST_FETCH;
    endcase

    // Instruction-type flags are meaningful once the IR holds the new opcode.
    if ((state_q == ST_DECODE) || (state_q == ST_EXEC) ||
        (state_q == ST_MEM) || (state_q == ST_WB)) begin
      intisCond = (ir_1 == OP_BRANCH);
      intisLoad = (ir_1 == OP_LOAD);
    end

    if (reset) begin
      aluOp        = 3'b000;
      memReq       = 1'b0;
      memReadWrite = 1'b0;
      irLoad       = 1'b0;
      pcLoad       = 1'b0;
      branch       = 1'b0;
      regLoad      = 1'b0;
      muxPP        = PP_NONE;
      muxpush      = 1'b0;
      muxreturn    = 1'b0;
      intisCond    = 1'b0;
      intisLoad    = 1'b0;
      fault        = 1'b0;
      state        = 3'b000;
    end
  end

endmodule
